bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
// - Shares the single memory_bus port (16-bit address, 8-bit data; banks RAM/ROM/periph/block RAM by addr[15:14])
//   between two requesters: port 0 = CPU, port 1 = DMA/loader engine.
// - Sequences each access as one transaction: arbitrate, drive bus, wait read latency, return data + ack.
// - Sits between the CPU/DMA and memory_bus; memory_bus stays unchanged.
// PARAMETERS
// - READ_LATENCY  1  clocks from address driven to mem_data_out valid (1..3)
// - CPU_PRIORITY  0  1 = port 0 always wins ties; 0 = round-robin on ties
// PORTS
// - clk            in   1   system clock; the only clock
// - reset          in   1   synchronous, active-high
// - req0/req1      in   1   transaction request, held high until ackN
// - addr0/addr1    in   16  request address
// - wdata0/wdata1  in   8   write data
// - we0/we1        in   1   1 = write, 0 = read
// - ack0/ack1      out  1   one-cycle pulse: transaction complete
// - rdata0/rdata1  out  8   read data, valid with ackN, held until next ackN
// - mem_address    out  16  to memory_bus address
// - mem_data_in    out  8   to memory_bus data_in
// - mem_data_out   in   8   from memory_bus data_out
// - mem_bus_enable out  1   high while a transaction owns the bus
// - mem_write_en   out  1   to memory_bus write_enable
// - owner          out  1   port currently or last granted (debug/status)
// BEHAVIOUR
// - Reset: state IDLE; ack0/ack1=0, rdata0/rdata1=8'h00, mem_address=0, mem_data_in=0,
//   mem_bus_enable=0, mem_write_en=0, owner=1 (so port 0 wins the first round-robin tie).
// - FSM: IDLE -> ACCESS -> (WAIT)* -> DONE -> IDLE.
//   IDLE: sample req0/req1; none -> stay. One -> grant it. Both -> CPU_PRIORITY ? port 0 : port != owner.
//   Grant latches addr/wdata/we of winner into internal regs; owner <= winner; next = ACCESS.
//   ACCESS: mem_bus_enable=1, mem_address/mem_data_in from latched regs; mem_write_en=latched we
//   for exactly this one cycle. Write -> DONE. Read -> WAIT with cnt=READ_LATENCY-1, or DONE if READ_LATENCY==1.
//   WAIT: bus signals held, mem_write_en=0; cnt decrements; cnt==0 -> DONE.
//   DONE: capture mem_data_out into rdataN (reads only; writes leave rdataN unchanged);
//   ackN=1 for this cycle; mem_bus_enable=0; next = IDLE.
// - Latency, req high in IDLE to ack: write 3 clks; read 3+READ_LATENCY-1 clks. Max 1 txn per 3 clks.
// - Requester changing addr/wdata/we after grant: ignored (latched copy used).
// - reqN dropped before ack: transaction still completes; ack still pulses (requester ignores it).
// - reqN still high in the IDLE cycle after ack: treated as a new request (back-to-back allowed;
//   round-robin alternates when both held).
// - Port not granted sees ack=0, and mem_* reflects only the owner.
// - Reset in any state: returns to IDLE next edge; in-flight txn aborted, no ack, mem_write_en=0.
// - Outputs ack*, rdata*, mem_* all registered; no combinational path req->mem_*.
// STRUCTURE
// - Shared package/include: state encodings (STATE_IDLE/ACCESS/WAIT/DONE), PORT_CPU=0, PORT_DMA=1.
// - One natural sub-module: arb_pick (combinational winner select: req0, req1, owner, CPU_PRIORITY -> grant, valid).
// - Latency counter + FSM + latch regs in bus_arbiter; width of cnt = 2 bits.
// TESTING
// - Reset held 2 clks mid-ACCESS write -> mem_write_en=0, state IDLE, no ack, all outputs at reset values.
// - req0 write addr 16'h0010 wdata 8'hA5 -> mem_write_en one cycle, ack0 at +3; read back -> rdata0=8'hA5.
// - req1 read 16'hC004 with READ_LATENCY=3 -> ack1 exactly 5 clks after req1, rdata1=model value.
// - req0 and req1 both held for 4 txns, CPU_PRIORITY=0 -> grants 0,1,0,1; CPU_PRIORITY=1 -> 0,0,0,0.
// - req0 changes addr to 16'h0020 one clk after grant -> bus still shows 16'h0010, ack0 unchanged timing.
// - req1 dropped during WAIT -> ack1 still pulses once; next IDLE grants pending req0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-port memory_bus arbiter.
// Port 0 is the CPU and port 1 is the DMA/loader engine.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_WAIT   = 2'd2,
        STATE_DONE   = 2'd3
    } state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester-side handshake for one arbiter port.
// The requester holds req, addr, wdata and we until it sees ack.
interface bus_arbiter_if;
    import bus_arbiter_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, addr, wdata, we, input ack, rdata);
    modport slave  (input req, addr, wdata, we, output ack, rdata);

endinterface

// File: rtl/bus_arbiter_arb_pick.sv
// Combinational winner select between the two requesters.
// A lone request always wins; ties go by fixed priority or round-robin.
module bus_arbiter_arb_pick
    import bus_arbiter_pkg::*;
#(
    parameter bit CPU_PRIORITY = 1'b0
) (
    input  logic req0,
    input  logic req1,
    input  logic owner,
    output logic grant,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        grant = PORT_CPU;
        if (req0 && req1) begin
            // round-robin hands the tie to whichever port did not own the bus last
            grant = CPU_PRIORITY ? PORT_CPU : ~owner;
        end else if (req1) begin
            grant = PORT_DMA;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single memory_bus port between the CPU (port 0) and the DMA engine (port 1).
// Each access runs as one arbitrated transaction; every output comes straight from a flop.
//
// state  | meaning
// IDLE   | bus free; sample requests and latch the winner's address/data/we
// ACCESS | bus driven from the latched copy; write strobe for this one cycle only
// WAIT   | read in flight; down-counter runs until the memory data is valid
// DONE   | bus released; read data captured and ack pulsed on the next edge
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          CPU_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    bus_arbiter_if.slave      port0,
    bus_arbiter_if.slave      port1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_bus_enable,
    output logic              mem_write_en,
    output logic              owner
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              txn_we_q, txn_we_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_bus_enable_q, mem_bus_enable_d;
    logic              mem_write_en_q, mem_write_en_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic pick_grant;
    logic pick_valid;

    bus_arbiter_arb_pick #(
        .CPU_PRIORITY (CPU_PRIORITY)
    ) u_arb_pick (
        .req0  (port0.req),
        .req1  (port1.req),
        .owner (owner_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        owner_d          = owner_q;
        txn_we_d         = txn_we_q;
        mem_address_d    = mem_address_q;
        mem_data_in_d    = mem_data_in_q;
        mem_bus_enable_d = 1'b0;
        mem_write_en_d   = 1'b0;
        ack0_d           = 1'b0;
        ack1_d           = 1'b0;
        rdata0_d         = rdata0_q;
        rdata1_d         = rdata1_q;

        case (state_q)
            STATE_IDLE: begin
                if (pick_valid) begin
                    owner_d          = pick_grant;
                    mem_address_d    = (pick_grant == PORT_DMA) ? port1.addr  : port0.addr;
                    mem_data_in_d    = (pick_grant == PORT_DMA) ? port1.wdata : port0.wdata;
                    txn_we_d         = (pick_grant == PORT_DMA) ? port1.we    : port0.we;
                    mem_write_en_d   = txn_we_d;
                    mem_bus_enable_d = 1'b1;
                    state_d          = STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                if (txn_we_q || READ_LATENCY == 32'd1) begin
                    state_d = STATE_DONE;
                end else begin
                    cnt_d            = CNT_W'(READ_LATENCY - 32'd1);
                    mem_bus_enable_d = 1'b1;
                    state_d          = STATE_WAIT;
                end
            end
            STATE_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = STATE_DONE;
                end else begin
                    mem_bus_enable_d = 1'b1;
                end
            end
            STATE_DONE: begin
                if (owner_q == PORT_CPU) begin
                    ack0_d = 1'b1;
                    if (!txn_we_q) rdata0_d = mem_data_out;
                end else begin
                    ack1_d = 1'b1;
                    if (!txn_we_q) rdata1_d = mem_data_out;
                end
                state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= STATE_IDLE;
            cnt_q            <= '0;
            owner_q          <= PORT_DMA;
            txn_we_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_data_in_q    <= '0;
            mem_bus_enable_q <= 1'b0;
            mem_write_en_q   <= 1'b0;
            ack0_q           <= 1'b0;
            ack1_q           <= 1'b0;
            rdata0_q         <= '0;
            rdata1_q         <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            owner_q          <= owner_d;
            txn_we_q         <= txn_we_d;
            mem_address_q    <= mem_address_d;
            mem_data_in_q    <= mem_data_in_d;
            mem_bus_enable_q <= mem_bus_enable_d;
            mem_write_en_q   <= mem_write_en_d;
            ack0_q           <= ack0_d;
            ack1_q           <= ack1_d;
            rdata0_q         <= rdata0_d;
            rdata1_q         <= rdata1_d;
        end
    end

    assign port0.ack      = ack0_q;
    assign port0.rdata    = rdata0_q;
    assign port1.ack      = ack1_q;
    assign port1.rdata    = rdata1_q;
    assign mem_address    = mem_address_q;
    assign mem_data_in    = mem_data_in_q;
    assign mem_bus_enable = mem_bus_enable_q;
    assign mem_write_en   = mem_write_en_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: dut_a (read latency 3, round-robin), dut_b (latency 1, CPU priority).
// Each memory model returns addr[7:0]^addr[15:8]^8'h3C for locations never written.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bus_arbiter_if ia0 ();
    bus_arbiter_if ia1 ();
    bus_arbiter_if ib0 ();
    bus_arbiter_if ib1 ();

    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_din, a_dout, b_din, b_dout;
    logic        a_en, a_we, a_owner, b_en, b_we, b_owner;

    bus_arbiter #(.READ_LATENCY(3), .CPU_PRIORITY(1'b0)) u_dut_a (
        .clk (clk), .reset (reset), .port0 (ia0), .port1 (ia1),
        .mem_address (a_addr), .mem_data_in (a_din), .mem_data_out (a_dout),
        .mem_bus_enable (a_en), .mem_write_en (a_we), .owner (a_owner)
    );

    bus_arbiter #(.READ_LATENCY(1), .CPU_PRIORITY(1'b1)) u_dut_b (
        .clk (clk), .reset (reset), .port0 (ib0), .port1 (ib1),
        .mem_address (b_addr), .mem_data_in (b_din), .mem_data_out (b_dout),
        .mem_bus_enable (b_en), .mem_write_en (b_we), .owner (b_owner)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // memory A: writable, data valid three clocks after the address is driven
    logic [7:0] mem_a [0:65535];
    logic [7:0] pa0, pa1, pa2;
    always @(posedge clk) begin
        if (a_en && a_we) mem_a[a_addr] <= a_din;
        pa0 <= mem_a[a_addr];
        pa1 <= pa0;
        pa2 <= pa1;
    end
    assign a_dout = pa2;

    logic [7:0] pb0;
    always @(posedge clk) pb0 <= init_val(b_addr);
    assign b_dout = pb0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_a(input bit port, input logic [15:0] addr, input logic [7:0] wd, input bit we,
                         input bit chg, output int lat, output int we_cnt, output logic [15:0] af,
                         output logic [15:0] al, output logic [7:0] din_we, output int other);
        bit seen = 1'b0;
        lat = -1; we_cnt = 0; af = 16'h0; al = 16'h0; din_we = 8'h0; other = 0;
        if (port) begin ia1.addr = addr; ia1.wdata = wd; ia1.we = we; ia1.req = 1'b1; end
        else      begin ia0.addr = addr; ia0.wdata = wd; ia0.we = we; ia0.req = 1'b1; end
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (a_en) begin
                if (!seen) af = a_addr;
                seen = 1'b1;
                al = a_addr;
            end
            if (a_we) begin we_cnt++; din_we = a_din; end
            if (chg && c == 1) begin
                if (port) ia1.addr = 16'h0020; else ia0.addr = 16'h0020;
            end
            if (port ? ia0.ack : ia1.ack) other++;
            if (port ? ia1.ack : ia0.ack) begin lat = c; break; end
        end
        if (port) ia1.req = 1'b0; else ia0.req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (a_en !== 1'b0 || a_we !== 1'b0) begin errors++; $display("FAIL reset_bus_ctl: en=%b we=%b, want 0 0", a_en, a_we); end
        checks++; if ({a_addr, a_din} !== 24'h0) begin errors++; $display("FAIL reset_bus_data: addr=%h din=%h, want 0000 00", a_addr, a_din); end
        checks++; if (a_owner !== 1'b1 || b_owner !== 1'b1) begin errors++; $display("FAIL reset_owner: a=%b b=%b, want 1 1", a_owner, b_owner); end
        checks++; if ({ia0.ack, ia1.ack, ib0.ack, ib1.ack} !== 4'b0) begin errors++; $display("FAIL reset_ack: %b, want 0000", {ia0.ack, ia1.ack, ib0.ack, ib1.ack}); end
        checks++; if ({ia0.rdata, ia1.rdata} !== 16'h0) begin errors++; $display("FAIL reset_rdata: %h %h, want 00 00", ia0.rdata, ia1.rdata); end
        checks++; if (u_dut_a.state_q !== STATE_IDLE) begin errors++; $display("FAIL reset_state: %0d, want IDLE", u_dut_a.state_q); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        ia0.addr = 16'h0030; ia0.wdata = 8'h5A; ia0.we = 1'b1; ia0.req = 1'b1;
        tick;
        checks++; if (a_en !== 1'b1 || a_we !== 1'b1) begin errors++; $display("FAIL midreset_access: en=%b we=%b, want 1 1", a_en, a_we); end
        reset = 1'b1; ia0.req = 1'b0;
        tick; tick;
        checks++; if (a_we !== 1'b0 || a_en !== 1'b0) begin errors++; $display("FAIL midreset_bus_ctl: en=%b we=%b, want 0 0", a_en, a_we); end
        checks++; if (u_dut_a.state_q !== STATE_IDLE) begin errors++; $display("FAIL midreset_state: %0d, want IDLE", u_dut_a.state_q); end
        checks++; if ({a_addr, a_din} !== 24'h0 || a_owner !== 1'b1) begin errors++; $display("FAIL midreset_regs: addr=%h din=%h owner=%b, want 0000 00 1", a_addr, a_din, a_owner); end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            acks += int'(ia0.ack) + int'(ia1.ack);
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL midreset_no_ack: %0d acks, want 0", acks); end
    endtask

    task automatic test_round_robin;
        int seq[4] = '{-1, -1, -1, -1};
        int n = 0;
        int dual = 0;
        ia0.addr = 16'h4001; ia0.we = 1'b0; ia0.req = 1'b1;
        ia1.addr = 16'h8002; ia1.we = 1'b0; ia1.req = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick;
            if (ia0.ack && ia1.ack) dual++;
            else if (ia0.ack) begin seq[n] = 0; n++; end
            else if (ia1.ack) begin seq[n] = 1; n++; end
        end
        ia0.req = 1'b0; ia1.req = 1'b0;
        checks++; if (n !== 4 || dual !== 0) begin errors++; $display("FAIL rr_count: %0d grants %0d dual acks, want 4 0", n, dual); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq[i] !== i % 2) begin errors++; $display("FAIL rr_order[%0d]: port %0d, want %0d", i, seq[i], i % 2); end
        end
        checks++; if (ia0.rdata !== 8'h7D || ia1.rdata !== 8'hBE) begin errors++; $display("FAIL rr_rdata: %h %h, want 7d be", ia0.rdata, ia1.rdata); end
        tick; tick;
    endtask

    task automatic test_write_read;
        int lat, wec, oth;
        logic [15:0] af, al;
        logic [7:0] dw;
        run_a(1'b0, 16'h0010, 8'hA5, 1'b1, 1'b0, lat, wec, af, al, dw, oth);
        checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: %0d clks, want 3", lat); end
        checks++; if (wec !== 1 || dw !== 8'hA5) begin errors++; $display("FAIL wr_strobe: %0d cycles data %h, want 1 a5", wec, dw); end
        checks++; if (af !== 16'h0010 || oth !== 0) begin errors++; $display("FAIL wr_bus: addr %h other acks %0d, want 0010 0", af, oth); end
        checks++; if (ia0.rdata !== 8'h7D) begin errors++; $display("FAIL wr_rdata_held: %h, want 7d", ia0.rdata); end
        run_a(1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, lat, wec, af, al, dw, oth);
        checks++; if (lat !== 5 || wec !== 0) begin errors++; $display("FAIL rd_back_timing: %0d clks %0d strobes, want 5 0", lat, wec); end
        checks++; if (ia0.rdata !== 8'hA5) begin errors++; $display("FAIL rd_back_data: %h, want a5", ia0.rdata); end
    endtask

    task automatic test_read_latency;
        int lat, wec, oth;
        logic [15:0] af, al;
        logic [7:0] dw;
        tick;
        run_a(1'b1, 16'hC004, 8'h00, 1'b0, 1'b0, lat, wec, af, al, dw, oth);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rd_lat3: %0d clks, want 5", lat); end
        checks++; if (ia1.rdata !== 8'hF8) begin errors++; $display("FAIL rd_lat3_data: %h, want f8", ia1.rdata); end
        checks++; if (oth !== 0 || ia0.rdata !== 8'hA5) begin errors++; $display("FAIL rd_lat3_other: acks %0d rdata0 %h, want 0 a5", oth, ia0.rdata); end
    endtask

    task automatic test_addr_change;
        int lat, wec, oth;
        logic [15:0] af, al;
        logic [7:0] dw;
        tick;
        run_a(1'b0, 16'h0010, 8'h00, 1'b0, 1'b1, lat, wec, af, al, dw, oth);
        checks++; if (af !== 16'h0010 || al !== 16'h0010) begin errors++; $display("FAIL chg_addr: first %h last %h, want 0010 0010", af, al); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL chg_latency: %0d clks, want 5", lat); end
        checks++; if (ia0.rdata !== 8'hA5) begin errors++; $display("FAIL chg_rdata: %h, want a5", ia0.rdata); end
        ia0.addr = 16'h0000;
    endtask

    task automatic test_drop_during_wait;
        int n_ack1 = 0;
        int lat0 = -1;
        tick;
        ia1.addr = 16'hC008; ia1.we = 1'b0; ia1.req = 1'b1;
        tick;
        checks++; if (a_owner !== 1'b1 || a_addr !== 16'hC008) begin errors++; $display("FAIL drop_grant: owner %b addr %h, want 1 c008", a_owner, a_addr); end
        ia0.addr = 16'h4001; ia0.we = 1'b0; ia0.req = 1'b1;
        tick; n_ack1 += int'(ia1.ack);
        ia1.req = 1'b0;
        tick; n_ack1 += int'(ia1.ack);
        tick; n_ack1 += int'(ia1.ack);
        tick; n_ack1 += int'(ia1.ack);
        checks++; if (ia1.ack !== 1'b1 || ia0.ack !== 1'b0) begin errors++; $display("FAIL drop_ack: ack1 %b ack0 %b, want 1 0", ia1.ack, ia0.ack); end
        checks++; if (ia1.rdata !== 8'hF4) begin errors++; $display("FAIL drop_rdata: %h, want f4", ia1.rdata); end
        tick; n_ack1 += int'(ia1.ack);
        checks++; if (a_owner !== 1'b0 || a_en !== 1'b1 || a_addr !== 16'h4001) begin errors++; $display("FAIL drop_next_grant: owner %b en %b addr %h, want 0 1 4001", a_owner, a_en, a_addr); end
        for (int c = 1; c <= 10; c++) begin
            tick; n_ack1 += int'(ia1.ack);
            if (ia0.ack) begin lat0 = c; break; end
        end
        ia0.req = 1'b0;
        checks++; if (lat0 !== 4) begin errors++; $display("FAIL drop_pending_lat: %0d clks after grant, want 4", lat0); end
        checks++; if (n_ack1 !== 1) begin errors++; $display("FAIL drop_ack_count: %0d pulses, want 1", n_ack1); end
        checks++; if (ia0.rdata !== 8'h7D) begin errors++; $display("FAIL drop_pending_data: %h, want 7d", ia0.rdata); end
    endtask

    task automatic test_priority;
        int seq[4] = '{-1, -1, -1, -1};
        int n = 0;
        int ack1s = 0;
        ib0.addr = 16'h4001; ib0.we = 1'b0; ib0.req = 1'b1;
        ib1.addr = 16'h0200; ib1.wdata = 8'h22; ib1.we = 1'b1; ib1.req = 1'b1;
        for (int c = 0; c < 30 && n < 4; c++) begin
            tick;
            if (ib1.ack) ack1s++;
            if (ib0.ack) begin seq[n] = 0; n++; end
        end
        ib0.req = 1'b0; ib1.req = 1'b0;
        checks++; if (n !== 4 || ack1s !== 0) begin errors++; $display("FAIL prio_count: %0d cpu grants %0d dma acks, want 4 0", n, ack1s); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (seq[i] !== 0) begin errors++; $display("FAIL prio_order[%0d]: port %0d, want 0", i, seq[i]); end
        end
        checks++; if (ib0.rdata !== 8'h7D || ib1.rdata !== 8'h00) begin errors++; $display("FAIL prio_rdata: %h %h, want 7d 00", ib0.rdata, ib1.rdata); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem_a[i] = init_val(16'(i));
        ia0.req = 1'b0; ia0.addr = 16'h0; ia0.wdata = 8'h0; ia0.we = 1'b0;
        ia1.req = 1'b0; ia1.addr = 16'h0; ia1.wdata = 8'h0; ia1.we = 1'b0;
        ib0.req = 1'b0; ib0.addr = 16'h0; ib0.wdata = 8'h0; ib0.we = 1'b0;
        ib1.req = 1'b0; ib1.addr = 16'h0; ib1.wdata = 8'h0; ib1.we = 1'b0;
        test_reset;
        test_reset_mid_access;
        test_round_robin;
        test_write_read;
        test_read_latency;
        test_addr_change;
        test_drop_during_wait;
        test_priority;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
